// File: rtl/count_seq_monitor.sv
// Sequence monitor for the 3-bit binary/gray mode counter: checks each step,
// decodes the value for a 7-segment digit and reports lock/wrap/error status.
module count_seq_monitor #(
    parameter int LOCK_LEN    = 8,
    parameter int ERR_W       = 8,
    parameter bit SEG_ACT_LOW = 1'b1
) (
    input  logic             CLOCK,
    input  logic             nRESET,
    input  logic             M,
    input  logic [2:0]       COUNT,
    output logic [2:0]       BIN,
    output logic [6:0]       SEG,
    output logic             VALID,
    output logic             LOCKED,
    output logic             WRAP,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT
);

    typedef enum logic [1:0] {S_INIT, S_ACQ, S_LOCK} state_t;

    localparam logic [3:0]       LOCK_LEN_C = 4'(LOCK_LEN);
    localparam logic [ERR_W-1:0] ERR_ONE    = ERR_W'(1);
    localparam logic [ERR_W-1:0] ERR_MAX    = {ERR_W{1'b1}};
    localparam logic [6:0]       SEG_BLANK  = SEG_ACT_LOW ? 7'h7F : 7'h00;

    state_t           state_r, state_s;
    logic [2:0]       p_cnt_r;
    logic             p_m_r;
    logic [3:0]       run_r, run_s, run_inc_s;
    logic             smp_vld_r, vld_s;
    logic             locked_s, wrap_s, err_s, legal_s;
    logic [ERR_W-1:0] errcnt_s;
    logic [2:0]       bin_s;
    logic [6:0]       seg_s;

    function automatic logic [2:0] succ(input logic [2:0] x, input logic m);
        logic [2:0] r;
        if (!m) begin
            r = x + 3'd1;
        end else begin
            case (x)
                3'b000:  r = 3'b001;
                3'b001:  r = 3'b011;
                3'b011:  r = 3'b010;
                3'b010:  r = 3'b110;
                3'b110:  r = 3'b111;
                3'b111:  r = 3'b101;
                3'b101:  r = 3'b100;
                3'b100:  r = 3'b000;
                default: r = 3'b000;
            endcase
        end
        return r;
    endfunction

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [6:0] seg_map(input logic [2:0] b);
        logic [6:0] s;
        case (b)
            3'd0:    s = 7'h3F;
            3'd1:    s = 7'h06;
            3'd2:    s = 7'h5B;
            3'd3:    s = 7'h4F;
            3'd4:    s = 7'h66;
            3'd5:    s = 7'h6D;
            3'd6:    s = 7'h7D;
            3'd7:    s = 7'h07;
            default: s = 7'h00;
        endcase
        return SEG_ACT_LOW ? ~s : s;
    endfunction

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        logic [ERR_W-1:0] r;
        if (v == ERR_MAX) begin
            r = v;
        end else begin
            r = v + ERR_ONE;
        end
        return r;
    endfunction

    // Decode of the previously captured sample; feeds the registered display stage.
    always_comb begin
        bin_s = 3'd0;
        if (p_m_r) begin
            bin_s = gray2bin(p_cnt_r);
        end else begin
            bin_s = p_cnt_r;
        end
        seg_s = seg_map(bin_s);
    end

    // Step check and next-state logic; the step is judged against the mode captured with the older sample.
    always_comb begin
        state_s   = state_r;
        run_s     = run_r;
        run_inc_s = run_r + 4'd1;
        locked_s  = LOCKED;
        wrap_s    = 1'b0;
        err_s     = 1'b0;
        errcnt_s  = ERR_CNT;
        vld_s     = smp_vld_r;
        legal_s   = (COUNT == succ(p_cnt_r, p_m_r));
        case (state_r)
            S_INIT: begin
                state_s = S_ACQ;
                run_s   = 4'd0;
                vld_s   = 1'b1;
            end
            S_ACQ: begin
                if (legal_s) begin
                    run_s  = run_inc_s;
                    wrap_s = (COUNT == 3'd0);
                    if (run_inc_s == LOCK_LEN_C) begin
                        state_s  = S_LOCK;
                        locked_s = 1'b1;
                    end else begin
                        state_s  = S_ACQ;
                    end
                end else begin
                    err_s    = 1'b1;
                    run_s    = 4'd0;
                    errcnt_s = sat_inc(ERR_CNT);
                end
            end
            S_LOCK: begin
                if (legal_s) begin
                    wrap_s = (COUNT == 3'd0);
                end else begin
                    err_s    = 1'b1;
                    run_s    = 4'd0;
                    locked_s = 1'b0;
                    state_s  = S_ACQ;
                    errcnt_s = sat_inc(ERR_CNT);
                end
            end
            default: begin
                state_s  = S_INIT;
                run_s    = 4'd0;
                locked_s = 1'b0;
            end
        endcase
    end

    // Negative-edge state and output registers with synchronous active-low reset.
    always_ff @(negedge CLOCK) begin
        if (!nRESET) begin
            state_r   <= S_INIT;
            p_cnt_r   <= 3'd0;
            p_m_r     <= 1'b0;
            run_r     <= 4'd0;
            smp_vld_r <= 1'b0;
            BIN       <= 3'd0;
            SEG       <= SEG_BLANK;
            VALID     <= 1'b0;
            LOCKED    <= 1'b0;
            WRAP      <= 1'b0;
            ERR       <= 1'b0;
            ERR_CNT   <= {ERR_W{1'b0}};
        end else begin
            state_r   <= state_s;
            p_cnt_r   <= COUNT;
            p_m_r     <= M;
            run_r     <= run_s;
            smp_vld_r <= vld_s;
            VALID     <= smp_vld_r;
            LOCKED    <= locked_s;
            WRAP      <= wrap_s;
            ERR       <= err_s;
            ERR_CNT   <= errcnt_s;
            if (smp_vld_r) begin
                BIN <= bin_s;
                SEG <= seg_s;
            end else begin
                BIN <= BIN;
                SEG <= SEG;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_monitor.sv
// Directed bench for count_seq_monitor: two configurations driven in parallel
// and compared every cycle against a rule-level model, plus literal pins.
module tb_count_seq_monitor;

    logic       CLOCK = 1'b0;
    logic       nRESET = 1'b0;
    logic       M = 1'b0;
    logic [2:0] COUNT = 3'd0;

    logic [2:0] bin0, bin1;
    logic [6:0] seg0, seg1;
    logic       valid0, valid1, locked0, locked1, wrap0, wrap1, err0, err1;
    logic [7:0] errcnt0;
    logic [1:0] errcnt1;

    count_seq_monitor dut0 (
        .CLOCK(CLOCK), .nRESET(nRESET), .M(M), .COUNT(COUNT),
        .BIN(bin0), .SEG(seg0), .VALID(valid0), .LOCKED(locked0),
        .WRAP(wrap0), .ERR(err0), .ERR_CNT(errcnt0)
    );

    count_seq_monitor #(.LOCK_LEN(3), .ERR_W(2), .SEG_ACT_LOW(1'b0)) dut1 (
        .CLOCK(CLOCK), .nRESET(nRESET), .M(M), .COUNT(COUNT),
        .BIN(bin1), .SEG(seg1), .VALID(valid1), .LOCKED(locked1),
        .WRAP(wrap1), .ERR(err1), .ERR_CNT(errcnt1)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    int    gray_seq[8] = '{0, 1, 3, 2, 6, 7, 5, 4};
    string seg_txt[8]  = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc"};
    int    cfg_lock[2] = '{8, 3};
    int    cfg_max[2]  = '{255, 3};
    bit    cfg_low[2]  = '{1'b1, 1'b0};

    int m_pc[2], m_pm[2], m_run[2];
    bit m_started[2], m_pend[2], m_locked[2];
    int e_bin[2], e_seg[2], e_valid[2], e_lock[2], e_wrap[2], e_err[2], e_cnt[2];
    bit model_ready = 1'b0;

    function automatic int gray_pos(input int g);
        for (int i = 0; i < 8; i++) if (gray_seq[i] == g) return i;
        return -1;
    endfunction

    function automatic int m_succ(input int x, input int m);
        if (m == 0) return (x + 1) % 8;
        return gray_seq[(gray_pos(x) + 1) % 8];
    endfunction

    function automatic int m_dec(input int x, input int m);
        return (m == 0) ? x : gray_pos(x);
    endfunction

    function automatic int m_seg(input int b, input bit low);
        int s = 0;
        string t = seg_txt[b];
        for (int i = 0; i < t.len(); i++) s |= (1 << (t[i] - 8'd97));
        return low ? (s ^ 'h7F) : s;
    endfunction

    // Model update on each active (falling) edge from the applied inputs.
    always @(negedge CLOCK) begin
        for (int c = 0; c < 2; c++) begin
            if (!nRESET) begin
                m_started[c] = 0; m_pend[c] = 0; m_locked[c] = 0; m_run[c] = 0;
                e_bin[c] = 0; e_valid[c] = 0; e_lock[c] = 0; e_wrap[c] = 0;
                e_err[c] = 0; e_cnt[c] = 0; e_seg[c] = cfg_low[c] ? 'h7F : 0;
            end else begin
                if (m_pend[c]) begin
                    e_bin[c]   = m_dec(m_pc[c], m_pm[c]);
                    e_seg[c]   = m_seg(e_bin[c], cfg_low[c]);
                    e_valid[c] = 1;
                end
                if (!m_started[c]) begin
                    m_started[c] = 1; m_pend[c] = 1; m_run[c] = 0;
                    e_wrap[c] = 0; e_err[c] = 0;
                end else if (int'(COUNT) == m_succ(m_pc[c], m_pm[c])) begin
                    e_wrap[c] = (COUNT == 3'd0);
                    e_err[c]  = 0;
                    if (!m_locked[c]) begin
                        m_run[c]++;
                        if (m_run[c] == cfg_lock[c]) m_locked[c] = 1;
                    end
                end else begin
                    e_err[c] = 1; e_wrap[c] = 0; m_run[c] = 0; m_locked[c] = 0;
                    if (e_cnt[c] < cfg_max[c]) e_cnt[c]++;
                end
                m_pc[c] = int'(COUNT);
                m_pm[c] = int'(M);
                e_lock[c] = m_locked[c];
            end
        end
        model_ready = 1'b1;
    end

    // Per-cycle comparison, on the rising edge away from the active edge.
    always @(posedge CLOCK) begin
        if (model_ready) begin
            check("bin0", bin0, e_bin[0]);       check("bin1", bin1, e_bin[1]);
            check("seg0", seg0, e_seg[0]);       check("seg1", seg1, e_seg[1]);
            check("valid0", valid0, e_valid[0]); check("valid1", valid1, e_valid[1]);
            check("locked0", locked0, e_lock[0]); check("locked1", locked1, e_lock[1]);
            check("wrap0", wrap0, e_wrap[0]);    check("wrap1", wrap1, e_wrap[1]);
            check("err0", err0, e_err[0]);       check("err1", err1, e_err[1]);
            check("errcnt0", errcnt0, e_cnt[0]); check("errcnt1", errcnt1, e_cnt[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input int c, input bit m, input bit r);
        @(posedge CLOCK);
        #1;
        COUNT  = 3'(c);
        M      = m;
        nRESET = r;
    endtask

    task automatic wait_neg();
        @(negedge CLOCK);
        #1;
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(0, 1'b0, 1'b0);
    endtask

    initial begin
        // binary run
        do_reset(2);
        for (int i = 0; i < 8; i++) drive(i, 1'b0, 1'b1);
        drive(0, 1'b0, 1'b1);
        wait_neg();
        check("bin_locked", locked0, 1);
        check("bin_wrap", wrap0, 1);
        check("bin_errcnt", errcnt0, 0);
        check("bin_bin7", bin0, 7);
        check("bin_seg7_low", seg0, 32'h78);
        check("bin_seg7_high", seg1, 32'h07);
        check("model_seg7", e_seg[0], 32'h78);

        // gray run, twice round plus return to 000
        do_reset(1);
        for (int k = 0; k < 16; k++) drive(gray_seq[k % 8], 1'b1, 1'b1);
        drive(0, 1'b1, 1'b1);
        wait_neg();
        check("gray_wrap", wrap0, 1);
        check("gray_bin", bin0, 7);
        check("gray_errcnt", errcnt0, 0);
        check("model_gray_succ", m_succ(4, 1), 0);

        // legal mode switch
        do_reset(1);
        drive(0, 1'b0, 1'b1); drive(1, 1'b0, 1'b1); drive(2, 1'b1, 1'b1); drive(6, 1'b1, 1'b1);
        wait_neg();
        check("msw_legal_err", err0, 0);
        check("msw_lock_short", locked1, 1);

        // illegal mode switch, then lock / fault / relock / hold
        do_reset(1);
        drive(0, 1'b0, 1'b1); drive(1, 1'b0, 1'b1); drive(2, 1'b1, 1'b1); drive(3, 1'b0, 1'b1);
        wait_neg();
        check("msw_bad_err", err0, 1);
        check("msw_bad_cnt", errcnt0, 1);
        for (int i = 4; i < 12; i++) drive(i % 8, 1'b0, 1'b1);
        wait_neg();
        check("lock_a", locked0, 1);
        drive(5, 1'b0, 1'b1);
        wait_neg();
        check("fault_err", err0, 1);
        check("fault_unlock", locked0, 0);
        check("fault_cnt", errcnt0, 2);
        for (int i = 6; i < 13; i++) drive(i % 8, 1'b0, 1'b1);
        wait_neg();
        check("relock_early", locked0, 0);
        drive(5, 1'b0, 1'b1);
        wait_neg();
        check("relock", locked0, 1);
        drive(5, 1'b0, 1'b1);
        wait_neg();
        check("hold_err", err0, 1);
        check("hold_cnt", errcnt0, 3);
        for (int i = 6; i < 14; i++) drive(i % 8, 1'b0, 1'b1);
        drive(6, 1'b1, 1'b1); drive(7, 1'b1, 1'b1);
        wait_neg();
        check("locked_msw", locked0, 1);
        check("locked_msw_cnt", errcnt0, 3);

        // reset mid-run
        drive(0, 1'b0, 1'b0);
        wait_neg();
        check("rst_valid", valid0, 0);
        check("rst_seg_low", seg0, 32'h7F);
        check("rst_seg_high", seg1, 32'h00);
        check("rst_cnt", errcnt0, 0);
        check("rst_locked", locked0, 0);
        drive(3, 1'b0, 1'b1);
        wait_neg();
        check("resume_valid0", valid0, 0);
        drive(4, 1'b0, 1'b1);
        wait_neg();
        check("resume_valid1", valid0, 1);
        check("resume_bin", bin0, 3);
        check("resume_seg", seg0, 32'h30);

        // error counter saturation
        do_reset(1);
        drive(5, 1'b0, 1'b1);
        for (int k = 1; k <= 5; k++) begin
            drive(5, 1'b0, 1'b1);
            wait_neg();
            check("sat_err", err1, 1);
            check("sat_cnt2", errcnt1, (k < 3) ? k : 3);
            check("sat_cnt8", errcnt0, k);
        end
        drive(6, 1'b0, 1'b1);
        @(posedge CLOCK);
        #2;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/count_seq_monitor.md
Name: count_seq_monitor

Overview:
- Downstream consumer of the 3-bit binary/gray mode counter.
- Samples COUNT and M every falling edge, in the same clock domain as the counter.
- Checks that each step is the legal successor for the mode in force, decodes the value to binary, and drives one 7-segment digit.
- Reports lock, wrap and error status, with a saturating error counter, to the board-level status logic.

Parameters:
- LOCK_LEN, 8: consecutive legal steps required to assert LOCKED (legal range 1..15).
- ERR_W, 8: width of ERR_CNT; saturates at 2^ERR_W-1.
- SEG_ACT_LOW, 1: 1 means SEG is active-low, 0 means active-high.

Ports:
- CLOCK  in  1  clock; all state updates on the negative edge.
- nRESET  in  1  reset, synchronous, active-low.
- M  in  1  counter mode, same signal the counter sees; 0=binary, 1=gray.
- COUNT  in  3  counter state output.
- BIN  out  3  binary-decoded sample.
- SEG  out  7  {g,f,e,d,c,b,a} digit for BIN.
- VALID  out  1  BIN/SEG hold a decoded sample.
- LOCKED  out  1  LOCK_LEN consecutive legal steps observed.
- WRAP  out  1  one-cycle pulse on a legal step into 000.
- ERR  out  1  one-cycle pulse on an illegal step.
- ERR_CNT  out  ERR_W  saturating count of illegal steps.

Behaviour:
- Reset (nRESET=0 at a negedge):
  - State goes to S_INIT.
  - BIN=0, VALID=0, LOCKED=0, WRAP=0, ERR=0, ERR_CNT=0, run counter=0.
  - SEG=blank: all segments off, polarity per SEG_ACT_LOW.
  - Reset mid-operation behaves identically; no pending pulse survives.
- Sampling: each negedge out of reset registers s_cnt<=COUNT and s_m<=M.
  - The previous pair (p_cnt, p_m) is kept for checking.
  - The counter's step between consecutive samples was computed with the mode sampled alongside the earlier sample.
  - Expected value: exp = succ(p_cnt, p_m).
- succ, binary mode: (x+1) mod 8.
- succ, gray mode: 000→001→011→010→110→111→101→100→000.
- Decode: gray value g gives b2=g2, b1=g2^g1, b0=g2^g1^g0; binary passes through. Decode uses the M sampled with that COUNT.
- Outputs: BIN, SEG and VALID update 1 cycle after the sampling edge (registered).
- SEG segment sets, active-high before polarity:
  - 0: abcdef
  - 1: bc
  - 2: abdeg
  - 3: abcdg
  - 4: bcfg
  - 5: acdfg
  - 6: acdefg
  - 7: abc
- FSM:
  - S_INIT: first negedge after reset captures p_cnt/p_m, no check, VALID→1, go to S_ACQ with run=0.
  - S_ACQ, legal step (COUNT==exp): run++; when run reaches LOCK_LEN, go to S_LOCK and set LOCKED=1.
  - S_ACQ, illegal step: ERR pulse, run=0, stay in S_ACQ.
  - S_LOCK, legal step: stay.
  - S_LOCK, illegal step: ERR pulse, LOCKED=0, run=0, go to S_ACQ.
  - Every checked cycle: p_cnt<=COUNT, p_m<=M, whether the step was legal or illegal.
- Mode change (M≠p_m): the step is checked against p_m, the mode that produced it. A mode switch is not an error and does not drop lock.
- Held value (COUNT==p_cnt) is illegal.
- WRAP: pulses when a checked step is legal and COUNT==000; never on the S_INIT capture.
- ERR_CNT: +1 per ERR pulse; holds at all-ones, no rollover.
- ERR and WRAP are mutually exclusive. WRAP, ERR and LOCKED all assert at the same edge that registers the step; no extra latency.

Test Plan:
- Binary run: release reset with M=0 held, feed 000..111,000 → VALID at cycle 1, LOCKED after 8 legal steps, WRAP once on 111→000, ERR_CNT=0, SEG for 7 = abc.
- Gray run: M=1, feed the gray sequence twice → BIN shows 0,1,2,...,7,0; WRAP on 100→000; no ERR.
- Mode switch: binary 000,001,010 with M=0; M=1 sampled with 010; next COUNT=110 → legal, LOCKED unchanged. COUNT=011 instead → ERR=1, ERR_CNT=1.
- Fault injection while LOCKED: force COUNT 011→101 in binary mode → ERR pulse; LOCKED drops at that edge; relock after 8 further legal steps. Held value 101,101 → ERR.
- Reset mid-run: assert nRESET=0 for one negedge while LOCKED with ERR_CNT=3 → all outputs clear, SEG blank, VALID=0 next cycle; resumes from S_INIT.
- Saturation (ERR_W=2): inject 5 illegal steps → ERR_CNT 1,2,3,3,3; ERR pulses all 5 times.
